// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the bit-serial frame receiver.
package serial_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DATA      = 3'd1,
      PARITY    = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   // Bits per frame on the line: start + data + optional parity + stop.
   function automatic int unsigned frame_len(input int unsigned data_w,
                                             input int unsigned parity_en);
      return data_w + 2 + parity_en;
   endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous line.
module bit_sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start/data/parity/stop framing, LSB first,
// delivered through a single-entry valid/ready holding register.
module serial_frame_rx
   import serial_rx_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_d,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic              w_s;
   logic [DATA_W-1:0] w_shift_nx;
   logic              w_deliver_ok;

   rx_state_e         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_perr;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_parity_err;
   logic              r_frame_err;
   logic              r_overrun;

   bit_sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_d),
      .q     (w_s)
   );

   // New bit enters at the MSB so the LSB-first word ends up right-aligned.
   always_comb begin
      w_shift_nx             = r_shift;
      w_shift_nx[DATA_W-1]   = w_s;
      for (int i = 0; i < int'(DATA_W) - 1; i++) begin
         w_shift_nx[i] = r_shift[i+1];
      end
   end

   assign w_deliver_ok = !r_rx_valid || rx_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_perr       <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_s == START_BIT) begin
                  r_state <= DATA;
                  r_cnt   <= '0;
                  r_perr  <= 1'b0;
               end
            end
            DATA: begin
               r_shift <= w_shift_nx;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               r_perr  <= w_s ^ (^r_shift);
               r_state <= STOP;
            end
            STOP: begin
               if (w_s == LINE_IDLE) begin
                  if (w_deliver_ok) begin
                     r_rx_data    <= r_shift;
                     r_parity_err <= (PARITY_EN != 0) ? r_perr : 1'b0;
                     r_rx_valid   <= 1'b1;
                  end else begin
                     r_overrun <= 1'b1;
                  end
                  r_state <= IDLE;
               end else begin
                  r_frame_err <= 1'b1;
                  r_state     <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               // A stuck-low line must not be read as a stream of start bits.
               if (w_s == LINE_IDLE) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed scenarios plus random frames.
module tb_serial_frame_rx;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned PARITY_EN = 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              perr;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              rx_d;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              parity_err;
   logic              frame_err;
   logic              overrun;

   int n_checks = 0;
   int n_errors = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;
   int exp_ferr = 0;
   int exp_ovr  = 0;

   exp_t sb[$];

   logic              prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_perr = 1'b0;

   serial_frame_rx #(.DATA_W(DATA_W), .PARITY_EN(PARITY_EN)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_d       (rx_d),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_d = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < int'(DATA_W); i++) send_bit(d[i]);
      if (PARITY_EN != 0) send_bit(pbit);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   // Even parity over data+parity bit: any odd total is an error.
   task automatic expect_word(input logic [DATA_W-1:0] d, input logic pbit);
      exp_t e;
      e.data = d;
      e.perr = (PARITY_EN != 0) ? ((^d) ^ pbit) : 1'b0;
      sb.push_back(e);
   endtask

   // Monitor: pops on every handshake, tallies pulses, checks hold stability.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (prev_hold) begin
            check("hold_data", int'(rx_data), int'(prev_data));
            check("hold_perr", int'(parity_err), int'(prev_perr));
         end
         if (rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got 0x%0h with empty scoreboard", rx_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("word_data", int'(rx_data), int'(e.data));
               check("word_perr", int'(parity_err), int'(e.perr));
            end
         end
         if (frame_err) n_ferr++;
         if (overrun)   n_ovr++;
      end
      prev_hold = (reset === 1'b1) && rx_valid && !rx_ready;
      prev_data = rx_data;
      prev_perr = parity_err;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] d;
      logic              good_par;
      logic              stop_ok;
      logic              pbit;

      // Reset state
      reset    = 1'b0;
      rx_d     = 1'bx;
      rx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", int'(rx_valid), 0);
      check("rst_data", int'(rx_data), 0);
      check("rst_perr", int'(parity_err), 0);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_ovr", int'(overrun), 0);
      reset = 1'b1;
      idle(10);
      check("idle_valid", int'(rx_valid), 0);

      // 0xA5, correct parity, latency of exactly three edges, single-cycle valid
      expect_word(8'hA5, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1);
      rx_d = 1'b1;
      @(posedge clk); #1;
      check("lat_edge2_valid", int'(rx_valid), 0);
      @(posedge clk); #1;
      check("lat_edge3_valid", int'(rx_valid), 1);
      check("lat_edge3_data", int'(rx_data), 'hA5);
      @(posedge clk); #1;
      check("valid_one_cycle", int'(rx_valid), 0);
      idle(2);

      // 0x3C with wrong parity bit
      expect_word(8'h3C, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      idle(4);

      // Backpressure: second back-to-back frame is lost with one overrun pulse
      rx_ready = 1'b0;
      expect_word(8'h11, 1'b0);
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      exp_ovr++;
      idle(4);
      check("bp_valid", int'(rx_valid), 1);
      check("bp_data", int'(rx_data), 'h11);
      check("bp_overrun_cnt", n_ovr, exp_ovr);
      rx_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_accept_valid", int'(rx_valid), 0);
      check("bp_data_after_accept", int'(rx_data), 'h11);

      // Bad stop bit, line held low, then recovery
      send_frame(8'h55, 1'b0, 1'b0);
      exp_ferr++;
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      idle(4);
      check("ferr_cnt", n_ferr, exp_ferr);
      check("ferr_no_valid", int'(rx_valid), 0);
      check("ferr_sb_empty", sb.size(), 0);
      expect_word(8'h0F, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b1);
      idle(4);

      // Reset after D3 aborts the frame
      d = 8'hFF;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_valid", int'(rx_valid), 0);
      check("midrst_data", int'(rx_data), 0);
      reset = 1'b1;
      idle(3);
      check("postrst_valid", int'(rx_valid), 0);
      expect_word(8'h80, 1'b1);
      send_frame(8'h80, 1'b1, 1'b1);
      idle(4);

      // Random frames with random parity/stop faults and gaps
      for (int n = 0; n < 40; n++) begin
         d        = DATA_W'($urandom);
         good_par = ($urandom_range(0, 3) != 0);
         stop_ok  = ($urandom_range(0, 7) != 0);
         pbit     = (^d) ^ !good_par;
         if (stop_ok) expect_word(d, pbit);
         else         exp_ferr++;
         send_frame(d, pbit, stop_ok);
         if (!stop_ok) idle(1);
         idle(int'($urandom_range(0, 3)));
      end
      idle(6);

      check("final_sb_empty", sb.size(), 0);
      check("final_ferr_cnt", n_ferr, exp_ferr);
      check("final_ovr_cnt", n_ovr, exp_ovr);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
